// File: rtl/seg7_scan_display_if.sv
// seg7_scan_display_if
//   Bundles the load/convert handshake and the display pin outputs of
//   seg7_scan_display.
//   binary   : unsigned value to convert, sampled on an accepted load
//   load     : conversion request, accepted while busy is low
//   busy     : conversion in progress
//   done     : one-cycle pulse when the display registers update
//   overflow : last accepted value did not fit in NUM_DIGITS digits
//   segment  : active-low segments, bit order gfedcba
//   an       : active-low digit enables, one-hot-low
//   Modports: master = value source, slave = display driver.
interface seg7_scan_display_if #(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_W      = 27
);
    logic [BIN_W-1:0]      binary;
    logic                  load;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic [6:0]            segment;
    logic [NUM_DIGITS-1:0] an;

    modport master (
        output binary, load,
        input  busy, done, overflow, segment, an
    );

    modport slave (
        input  binary, load,
        output busy, done, overflow, segment, an
    );
endinterface

// File: rtl/seg7_scan_display.sv
// seg7_scan_display
//   Multi-digit common-anode seven-segment driver. A value accepted on
//   bus.load is converted to BCD with the shift/add-3 algorithm, one bit
//   per clock, and the finished digits are written to the display
//   registers in a single cycle. The digits are time-multiplexed, each
//   enabled for REFRESH_DIV clocks. Values above 10^NUM_DIGITS-1 set
//   overflow and show "F" on every digit.
//   Ports:
//     clk   : system clock, rising edge
//     reset : asynchronous, active-high, clears all state
//     bus   : seg7_scan_display_if.slave (binary/load/busy/done/
//             overflow/segment/an)
module seg7_scan_display #(
    parameter int NUM_DIGITS  = 4,
    parameter int BIN_W       = 27,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_LZ    = 1
) (
    input logic                clk,
    input logic                reset,
    seg7_scan_display_if.slave bus
);

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    // Range compare is done wide enough that neither the input nor the
    // decimal limit is truncated; if the limit exceeds 2^BIN_W-1 the
    // compare simply never fires.
    localparam int CMP_W = (BIN_W > 40) ? BIN_W + 1 : 40;
    localparam logic [CMP_W-1:0] MAX_VAL = CMP_W'(pow10(NUM_DIGITS) - 1);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam int RC_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_OVF
    } state_t;

    state_t             state;
    logic [BIN_W-1:0]   bin_sr;
    logic [BCD_W-1:0]   bcd;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_next;
    logic [CNT_W-1:0]   bit_cnt;
    logic [BCD_W-1:0]   disp;
    logic               too_big;

    logic [RC_W-1:0]       rcnt;
    logic [IDX_W-1:0]      idx;
    logic [NUM_DIGITS-1:0] lz;
    logic                  zrun;
    logic [3:0]            cur_digit;
    logic [6:0]            seg_next;

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    assign too_big = (CMP_W'(bus.binary) > MAX_VAL);

    // One shift/add-3 step: correct every BCD nibble >= 5, then shift in
    // the next binary bit (MSB first).
    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_adj[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
        end
        bcd_next = {bcd_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
    end

    // Conversion FSM. Display digits and overflow change only on the
    // final step (or the overflow step), so the display never tears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.overflow <= 1'b0;
            bin_sr       <= '0;
            bcd          <= '0;
            bit_cnt      <= '0;
            disp         <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.load) begin
                        bus.busy <= 1'b1;
                        if (too_big) begin
                            state <= S_OVF;
                        end else begin
                            state   <= S_CONV;
                            bin_sr  <= bus.binary;
                            bcd     <= '0;
                            bit_cnt <= CNT_W'(BIN_W - 1);
                        end
                    end
                end
                S_OVF: begin
                    state        <= S_IDLE;
                    bus.busy     <= 1'b0;
                    bus.done     <= 1'b1;
                    bus.overflow <= 1'b1;
                end
                S_CONV: begin
                    bin_sr <= {bin_sr[BIN_W-2:0], 1'b0};
                    bcd    <= bcd_next;
                    if (bit_cnt == '0) begin
                        state        <= S_IDLE;
                        bus.busy     <= 1'b0;
                        bus.done     <= 1'b1;
                        bus.overflow <= 1'b0;
                        disp         <= bcd_next;
                    end else begin
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

    // lz[i]: digit i and every more-significant digit are zero.
    // Digit 0 is never flagged so a zero value still shows "0".
    always_comb begin
        lz   = '0;
        zrun = 1'b1;
        for (int unsigned k = 0; k + 1 < NUM_DIGITS; k++) begin
            zrun = zrun & (disp[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
            lz[NUM_DIGITS-1-k] = zrun;
        end
    end

    always_comb begin
        cur_digit = disp[4*idx +: 4];
        if (bus.overflow)
            seg_next = SEG_F;
        else if ((BLANK_LZ != 0) && lz[idx])
            seg_next = SEG_BLANK;
        else
            seg_next = dec7(cur_digit);
    end

    // Scan: segment and an are both registered from the same idx, so the
    // pins never disagree about which digit is being driven.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rcnt        <= '0;
            idx         <= '0;
            bus.an      <= '1;
            bus.segment <= SEG_BLANK;
        end else begin
            bus.an      <= ~(NUM_DIGITS'(1) << idx);
            bus.segment <= seg_next;
            if (rcnt == RC_W'(REFRESH_DIV - 1)) begin
                rcnt <= '0;
                if (idx == IDX_W'(NUM_DIGITS - 1))
                    idx <= '0;
                else
                    idx <= idx + IDX_W'(1);
            end else begin
                rcnt <= rcnt + RC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display
//   Directed bench for seg7_scan_display (4 digits, 27-bit input,
//   4 clocks per digit). dut0 blanks leading zeros, dut1 does not; both
//   receive identical stimulus.
module tb_seg7_scan_display;

    localparam int ND = 4;
    localparam int BW = 27;
    localparam int RD = 4;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SF = 7'b0001110;
    localparam logic [6:0] SB = 7'b1111111;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    seg7_scan_display_if #(.NUM_DIGITS(ND), .BIN_W(BW)) bus0 ();
    seg7_scan_display_if #(.NUM_DIGITS(ND), .BIN_W(BW)) bus1 ();

    seg7_scan_display #(
        .NUM_DIGITS(ND), .BIN_W(BW), .REFRESH_DIV(RD), .BLANK_LZ(1)
    ) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave)
    );

    seg7_scan_display #(
        .NUM_DIGITS(ND), .BIN_W(BW), .REFRESH_DIV(RD), .BLANK_LZ(0)
    ) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [BW-1:0] v, input logic ld);
        bus0.binary = v;
        bus1.binary = v;
        bus0.load   = ld;
        bus1.load   = ld;
    endtask

    // Present v with load for exactly one edge (E0); returns after E0.
    task automatic do_load(input logic [BW-1:0] v);
        set_in(v, 1'b1);
        tick();
        set_in(v, 1'b0);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (bus0.done !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, 32'(bus0.done), 32'd1);
    endtask

    function automatic logic [ND-1:0] get_an(input int which);
        return (which == 0) ? bus0.an : bus1.an;
    endfunction

    function automatic logic [6:0] get_seg(input int which);
        return (which == 0) ? bus0.segment : bus1.segment;
    endfunction

    // Wait (bounded) until digit d is enabled, then check its segments.
    task automatic show(input int which, input int d, input logic [6:0] exp, input string tag);
        logic [ND-1:0] want;
        int n;
        want = ~(ND'(1) << d);
        n = 0;
        while (get_an(which) !== want && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_an"}, 32'(get_an(which)), 32'(want));
        chk({tag, "_seg"}, 32'(get_seg(which)), 32'(exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int n;
        int ndone;

        // 1: reset state, then first digit on the edge after release
        set_in('0, 1'b0);
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_an", 32'(bus0.an), 32'hF);
        chk("rst_seg", 32'(bus0.segment), 32'(SB));
        chk("rst_busy", 32'(bus0.busy), 32'd0);
        chk("rst_done", 32'(bus0.done), 32'd0);
        chk("rst_ovf", 32'(bus0.overflow), 32'd0);
        reset = 1'b0;
        tick();
        chk("rel_an", 32'(bus0.an), 32'b1110);
        chk("rel_seg", 32'(bus0.segment), 32'(S0));
        chk("rel_busy", 32'(bus0.busy), 32'd0);

        // 2: 1234, exact conversion latency and scan order/dwell
        do_load(27'd1234);
        chk("c_busy_e0", 32'(bus0.busy), 32'd1);
        repeat (26) tick();
        chk("c_busy_e26", 32'(bus0.busy), 32'd1);
        chk("c_done_e26", 32'(bus0.done), 32'd0);
        tick();
        chk("c_busy_e27", 32'(bus0.busy), 32'd0);
        chk("c_done_e27", 32'(bus0.done), 32'd1);
        chk("c_ovf_e27", 32'(bus0.overflow), 32'd0);
        tick();
        chk("c_done_e28", 32'(bus0.done), 32'd0);
        show(0, 0, S4, "v1234_d0");
        show(0, 1, S3, "v1234_d1");
        n = 0;
        while (bus0.an === 4'b1101 && n < 20) begin
            tick();
            n++;
        end
        chk("dwell_d1", 32'(n), 32'd4);
        chk("after_d1_an", 32'(bus0.an), 32'b1011);
        chk("v1234_d2_seg", 32'(bus0.segment), 32'(S2));
        show(0, 3, S1, "v1234_d3");

        // 3: leading-zero blanking versus no blanking, and value 0
        do_load(27'd7);
        wait_done("v7");
        tick();
        show(0, 0, S7, "v7_d0");
        show(0, 1, SB, "v7_d1");
        show(0, 3, SB, "v7_d3");
        show(1, 0, S7, "v7nb_d0");
        show(1, 1, S0, "v7nb_d1");
        show(1, 3, S0, "v7nb_d3");
        do_load(27'd0);
        wait_done("v0");
        tick();
        show(0, 0, S0, "v0_d0");
        show(0, 2, SB, "v0_d2");

        // 4: overflow boundary 10000, then the in-range maximum 9999
        do_load(27'd10000);
        chk("ovf_busy_e0", 32'(bus0.busy), 32'd1);
        tick();
        chk("ovf_done_e1", 32'(bus0.done), 32'd1);
        chk("ovf_busy_e1", 32'(bus0.busy), 32'd0);
        chk("ovf_flag", 32'(bus0.overflow), 32'd1);
        tick();
        show(0, 0, SF, "ovf_d0");
        show(0, 3, SF, "ovf_d3");
        do_load(27'd9999);
        chk("ovf_hold_conv", 32'(bus0.overflow), 32'd1);
        wait_done("v9999");
        chk("v9999_ovf", 32'(bus0.overflow), 32'd0);
        tick();
        show(0, 0, S9, "v9999_d0");
        show(0, 3, S9, "v9999_d3");

        // 5: load during busy ignored; load on the done cycle accepted
        do_load(27'd42);
        repeat (3) tick();
        do_load(27'd555);
        wait_done("v42");
        set_in(27'd8, 1'b1);
        tick();
        set_in(27'd8, 1'b0);
        chk("load_on_done", 32'(bus0.busy), 32'd1);
        show(0, 0, S2, "hold42_d0");
        chk("hold42_busy", 32'(bus0.busy), 32'd1);
        show(0, 1, S4, "hold42_d1");
        wait_done("v8");
        tick();
        show(0, 0, S8, "v8_d0");
        show(0, 1, SB, "v8_d1");

        // 6: reset in the middle of a conversion
        do_load(27'd1234);
        repeat (9) tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(bus0.busy), 32'd0);
        chk("mid_rst_an", 32'(bus0.an), 32'hF);
        tick();
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus0.done === 1'b1) ndone++;
        end
        chk("mid_rst_nodone", 32'(ndone), 32'd0);
        show(0, 0, S0, "mid_rst_d0");
        show(0, 1, SB, "mid_rst_d1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
